pipeline_hazard_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It keeps a three-slot scoreboard of in-flight destination registers and consumes the decoder's `Rs1_used`/`Rs2_used` flags, the EX-stage branch resolution and the memory `MIO_ready` handshake. From these it drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps performance and error counters.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 61 ++++++
 rtl/pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types for the 5-stage pipeline hazard controller:
//                scoreboard slot record, sequencer states, bubble constant
//                and the source/destination match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam slot_t BUBBLE_SLOT = '{wr: 1'b0, rd: 5'd0, load: 1'b0};

    // A source read collides with a slot only if it is really read, the slot
    // really writes, the indices agree and the index is not the zero register
    function automatic logic slot_match(input slot_t slot, input logic [4:0] rs,
                                        input logic used);
        return used & slot.wr & (slot.rd == rs) & (rs != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Three-slot (EX/MEM/WB) destination scoreboard and RAW
//                hazard detection against the instruction in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARD_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  slot_t      ex_next,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       hazard
);

    slot_t r_ex;
    slot_t r_mem;
    slot_t r_wb;
    logic  w_ex_hit;
    logic  w_mem_hit;
    logic  w_unused;

    // Shift the slots one stage on every non-frozen cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= BUBBLE_SLOT;
            r_mem <= BUBBLE_SLOT;
            r_wb  <= BUBBLE_SLOT;
        end else if (advance) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= ex_next;
        end
    end

    assign w_ex_hit  = slot_match(r_ex,  id_rs1, id_rs1_used) | slot_match(r_ex,  id_rs2, id_rs2_used);
    assign w_mem_hit = slot_match(r_mem, id_rs1, id_rs1_used) | slot_match(r_mem, id_rs2, id_rs2_used);

    // WB never stalls: the register file writes before it is read
    assign w_unused = ^{r_wb, r_mem};

    generate
        if (FORWARD_EN != 0) begin : g_forward
            // Bypass covers everything except a load still in EX
            assign hazard = id_valid & r_ex.load & w_ex_hit;
        end else begin : g_no_forward
            assign hazard = id_valid & (w_ex_hit | w_mem_hit);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for a 5-stage RISC-V pipeline.
//                Memory-wait FSM, freeze/redirect/hazard priority mux,
//                saturating performance counters and a sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARD_EN  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             MIO_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [31:0]      TMO_LIMIT = 32'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_freeze;
    logic             w_hazard;
    logic             w_do_redirect;
    logic             w_do_hazard;
    logic             w_normal;
    logic             w_tmo_hit;
    slot_t            w_ex_next;
    logic [7:0]       r_wait_tmr;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;

    assign w_freeze      = mem_req & ~MIO_ready;
    assign w_do_redirect = ~w_freeze & ex_redirect;
    assign w_do_hazard   = ~w_freeze & ~ex_redirect & w_hazard;
    assign w_normal      = ~w_freeze & ~ex_redirect & ~w_hazard;

    // Only a normally issued instruction enters EX; anything else is a bubble
    assign w_ex_next = w_normal ? '{wr:   id_valid & id_regwrite & (id_rd != 5'd0),
                                    rd:   id_rd,
                                    load: id_is_load}
                                : BUBBLE_SLOT;

    hazard_scoreboard #(
        .FORWARD_EN (FORWARD_EN)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (~w_freeze),
        .ex_next     (w_ex_next),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .hazard      (w_hazard)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: enter on a stalled access, leave once memory is ready
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_freeze)  w_state_next = MEM_WAIT;
            MEM_WAIT: if (MIO_ready) w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    // FSM outputs: priority freeze > redirect > hazard > normal, all off in reset
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst_n && !w_freeze) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_redirect) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_hazard) begin
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    // Timer counts cycles that end in MEM_WAIT; flag trips when it reaches the limit
    assign w_tmo_hit = (w_state_next == MEM_WAIT) &&
                       ((32'(r_wait_tmr) + 32'd1) >= TMO_LIMIT);

    // Wait timer and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_tmr    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_state_next == MEM_WAIT) begin
                if (r_wait_tmr != 8'hFF) r_wait_tmr <= r_wait_tmr + 8'd1;
            end else begin
                r_wait_tmr <= 8'd0;
            end
            if (w_tmo_hit) r_mem_timeout <= 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_do_hazard   && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_do_redirect && r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
            if (w_freeze      && r_wait_cnt  != CNT_MAX) r_wait_cnt  <= r_wait_cnt  + CNT_ONE;
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign wait_cnt    = r_wait_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. Two instances
//                (bypass / no bypass, timeout limit 4) share one stimulus;
//                a directed vector table, hand sequences for timeout and
//                asynchronous reset, then random traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] C_NORM  = 7'b1111100;
    localparam logic [6:0] C_STALL = 7'b0011101;
    localparam logic [6:0] C_REDIR = 7'b1111111;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam int         TMO     = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, mem_req, MIO_ready;

    logic        f_pc, f_ifid, f_idex, f_exmem, f_memwb, f_iff, f_idf, f_tmo;
    logic [31:0] f_stall, f_flush, f_wait;
    logic        n_pc, n_ifid, n_idex, n_exmem, n_memwb, n_iff, n_idf, n_tmo;
    logic [3:0]  n_stall, n_flush, n_wait;
    logic [6:0]  f_ctrl, n_ctrl;

    assign f_ctrl = {f_pc, f_ifid, f_idex, f_exmem, f_memwb, f_iff, f_idf};
    assign n_ctrl = {n_pc, n_ifid, n_idex, n_exmem, n_memwb, n_iff, n_idf};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FORWARD_EN(1), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut_f (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .MIO_ready(MIO_ready), .pc_en(f_pc), .ifid_en(f_ifid),
        .idex_en(f_idex), .exmem_en(f_exmem), .memwb_en(f_memwb), .ifid_flush(f_iff),
        .idex_flush(f_idf), .mem_timeout(f_tmo), .stall_cnt(f_stall), .flush_cnt(f_flush),
        .wait_cnt(f_wait));

    pipeline_hazard_ctrl #(.FORWARD_EN(0), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .MIO_ready(MIO_ready), .pc_en(n_pc), .ifid_en(n_ifid),
        .idex_en(n_idex), .exmem_en(n_exmem), .memwb_en(n_memwb), .ifid_flush(n_iff),
        .idex_flush(n_idf), .mem_timeout(n_tmo), .stall_cnt(n_stall), .flush_cnt(n_flush),
        .wait_cnt(n_wait));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instructions in flight behind ID (index 0 = EX)
    // ------------------------------------------------------------------
    typedef struct { bit wr; int rd; bit load; } ins_t;
    ins_t   mp [2][3];
    bit     m_wait [2];
    int     m_wlen [2];
    bit     m_tmo  [2];
    longint m_stall[2], m_flush[2], m_waitc[2];

    function automatic longint lim(input int d);
        return (d == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                mp[d][k].wr = 0; mp[d][k].rd = 0; mp[d][k].load = 0;
            end
            m_wait[d] = 0; m_wlen[d] = 0; m_tmo[d] = 0;
            m_stall[d] = 0; m_flush[d] = 0; m_waitc[d] = 0;
        end
    endtask

    // 0 normal, 1 hazard, 2 redirect, 3 freeze
    function automatic int m_mode(input int d);
        bit haz = 0;
        int depth = (d == 0) ? 1 : 2;
        if (mem_req && !MIO_ready) return 3;
        if (ex_redirect) return 2;
        for (int k = 0; k < depth; k++) begin
            if (mp[d][k].wr && (d == 1 || mp[d][k].load)) begin
                if (id_rs1_used && id_rs1 != 0 && int'(id_rs1) == mp[d][k].rd) haz = 1;
                if (id_rs2_used && id_rs2 != 0 && int'(id_rs2) == mp[d][k].rd) haz = 1;
            end
        end
        return (id_valid && haz) ? 1 : 0;
    endfunction

    function automatic logic [6:0] m_ctrl(input int d);
        if (!rst_n) return 7'd0;
        case (m_mode(d))
            0:       return C_NORM;
            1:       return C_STALL;
            2:       return C_REDIR;
            default: return C_FRZ;
        endcase
    endfunction

    task automatic m_update(input int d);
        int md = m_mode(d);
        if (md != 3) begin
            mp[d][2] = mp[d][1];
            mp[d][1] = mp[d][0];
            mp[d][0].wr   = (md == 0) && id_valid && id_regwrite && (id_rd != 0);
            mp[d][0].rd   = (md == 0) ? int'(id_rd) : 0;
            mp[d][0].load = (md == 0) && id_is_load;
        end
        if (md == 1 && m_stall[d] < lim(d)) m_stall[d]++;
        if (md == 2 && m_flush[d] < lim(d)) m_flush[d]++;
        if (md == 3 && m_waitc[d] < lim(d)) m_waitc[d]++;
        if (!m_wait[d]) m_wait[d] = (md == 3);
        else            m_wait[d] = !MIO_ready;
        m_wlen[d] = m_wait[d] ? ((m_wlen[d] < 255) ? m_wlen[d] + 1 : 255) : 0;
        if (m_wlen[d] >= TMO) m_tmo[d] = 1;
    endtask

    // One clock: compare at negedge, advance model at posedge
    task automatic do_cycle(input bit tab, input logic [6:0] ef, input logic [6:0] en,
                            input int etmo);
        @(negedge clk);
        cyc++;
        chk($sformatf("c%0d f_ctrl", cyc), f_ctrl, m_ctrl(0));
        chk($sformatf("c%0d n_ctrl", cyc), n_ctrl, m_ctrl(1));
        chk($sformatf("c%0d f_stall", cyc), f_stall, m_stall[0]);
        chk($sformatf("c%0d n_stall", cyc), n_stall, m_stall[1]);
        chk($sformatf("c%0d f_flush", cyc), f_flush, m_flush[0]);
        chk($sformatf("c%0d n_flush", cyc), n_flush, m_flush[1]);
        chk($sformatf("c%0d f_wait", cyc), f_wait, m_waitc[0]);
        chk($sformatf("c%0d n_wait", cyc), n_wait, m_waitc[1]);
        chk($sformatf("c%0d f_tmo", cyc), f_tmo, m_tmo[0]);
        chk($sformatf("c%0d n_tmo", cyc), n_tmo, m_tmo[1]);
        if (tab) begin
            chk($sformatf("c%0d tab f_ctrl", cyc), f_ctrl, ef);
            chk($sformatf("c%0d tab n_ctrl", cyc), n_ctrl, en);
        end
        if (etmo >= 0) begin
            chk($sformatf("c%0d exp f_tmo", cyc), f_tmo, etmo);
            chk($sformatf("c%0d exp n_tmo", cyc), n_tmo, etmo);
        end
        @(posedge clk);
        m_update(0);
        m_update(1);
        #1;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, " f_ctrl"}, f_ctrl, 0);
        chk({tag, " n_ctrl"}, n_ctrl, 0);
        chk({tag, " f_cnt"}, {f_stall, f_flush, f_wait}, 0);
        chk({tag, " n_cnt"}, {n_stall, n_flush, n_wait}, 0);
        chk({tag, " f_tmo"}, f_tmo, 0);
        chk({tag, " n_tmo"}, n_tmo, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct packed {
        logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
        logic [4:0] rd; logic rw; logic ld; logic redir; logic mreq; logic rdy;
        logic [6:0] ef; logic [6:0] en;
    } vec_t;

    vec_t tab [19];

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                                input logic u2, input int rd, input logic rw, input logic ld,
                                input logic redir, input logic mreq, input logic rdy,
                                input logic [6:0] ef, input logic [6:0] en);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
        r.rd = 5'(rd); r.rw = rw; r.ld = ld; r.redir = redir; r.mreq = mreq; r.rdy = rdy;
        r.ef = ef; r.en = en;
        return r;
    endfunction

    task automatic apply(input vec_t t);
        id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rs1_used = t.u1;
        id_rs2_used = t.u2; id_rd = t.rd; id_regwrite = t.rw; id_is_load = t.ld;
        ex_redirect = t.redir; mem_req = t.mreq; MIO_ready = t.rdy;
    endtask

    initial begin
        //             v rs1 rs2 u1 u2 rd rw ld rd mq ry   fwd      nofwd
        tab[0]  = mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 1, C_NORM,  C_NORM);   // lw x5
        tab[1]  = mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 1, C_STALL, C_STALL);  // add x6,x5,x7
        tab[2]  = mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 1, C_NORM,  C_STALL);
        tab[3]  = mk(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 1, C_NORM,  C_NORM);   // addi x3,x1
        tab[4]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, C_NORM,  C_STALL);  // sub x4,x3,x1
        tab[5]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, C_NORM,  C_STALL);
        tab[6]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, C_NORM,  C_NORM);
        tab[7]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, C_NORM,  C_NORM);   // addi x0,x1
        tab[8]  = mk(1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 1, C_NORM,  C_NORM);   // add x8,x0,x0
        tab[9]  = mk(1, 8, 8, 0, 0, 9, 1, 0, 0, 0, 1, C_NORM,  C_NORM);   // lui x9
        tab[10] = mk(1, 1, 9, 1, 0, 10, 1, 0, 0, 0, 1, C_NORM, C_NORM);   // rs2 field hits, unused
        tab[11] = mk(1, 1, 0, 1, 0, 11, 1, 1, 0, 0, 1, C_NORM, C_NORM);   // lw x11
        tab[12] = mk(1, 11, 11, 1, 1, 12, 1, 0, 1, 0, 1, C_REDIR, C_REDIR); // hazard + redirect
        tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NORM,  C_NORM);
        tab[14] = mk(1, 1, 0, 1, 0, 13, 1, 0, 1, 1, 0, C_FRZ,  C_FRZ);    // redirect under freeze
        tab[15] = mk(1, 1, 0, 1, 0, 13, 1, 0, 1, 1, 0, C_FRZ,  C_FRZ);
        tab[16] = mk(1, 1, 0, 1, 0, 13, 1, 0, 1, 1, 0, C_FRZ,  C_FRZ);
        tab[17] = mk(1, 1, 0, 1, 0, 13, 1, 0, 1, 1, 1, C_REDIR, C_REDIR); // ready: redirect lands
        tab[18] = mk(1, 13, 0, 1, 0, 14, 1, 0, 0, 0, 1, C_NORM, C_NORM);

        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NORM, C_NORM));
        model_reset();
        #2;
        reset_chk("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(tab[i]);
            do_cycle(1'b1, tab[i].ef, tab[i].en, -1);
        end
        chk("f stall total", f_stall, 1);
        chk("n stall total", n_stall, 4);
        chk("f flush total", f_flush, 2);
        chk("n flush total", n_flush, 2);
        chk("f wait total",  f_wait, 3);
        chk("n wait total",  n_wait, 3);

        // Timeout: ready low six cycles, flag from the fifth, sticky after
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NORM, C_NORM));
        for (int i = 1; i <= 6; i++) do_cycle(1'b1, C_FRZ, C_FRZ, (i >= 5) ? 1 : 0);
        MIO_ready = 1'b1;
        do_cycle(1'b1, C_NORM, C_NORM, 1);
        mem_req = 1'b0;
        do_cycle(1'b1, C_NORM, C_NORM, 1);

        // Asynchronous reset while in MEM_WAIT
        mem_req = 1'b1; MIO_ready = 1'b0;
        do_cycle(1'b0, C_FRZ, C_FRZ, -1);
        do_cycle(1'b0, C_FRZ, C_FRZ, -1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_chk("async");
        model_reset();
        apply(mk(1, 5, 5, 1, 1, 6, 1, 1, 0, 0, 0, C_NORM, C_NORM));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_update(0);
        m_update(1);
        #1;
        id_is_load = 1'b0;
        for (int i = 0; i < 6; i++) do_cycle(1'b1, C_NORM, C_NORM, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_valid    = ($urandom_range(0, 9) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 3));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_is_load  = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 6) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            MIO_ready   = ($urandom_range(0, 3) != 0);
            do_cycle(1'b0, C_NORM, C_NORM, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
